// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and checksum helpers for the framed-packet UART transmitter.
package uart_pkg;

    localparam int unsigned UART_FRAME_BITS = 10;

    localparam int unsigned CSUM_XOR = 0;
    localparam int unsigned CSUM_SUM = 1;
    localparam int unsigned CSUM_NEG = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StData,
        StCsum
    } txState_t;

    // XOR mode folds with XOR; both sum-based modes accumulate mod 256.
    function automatic logic [7:0] csumStep(input int unsigned mode, input logic [7:0] acc,
                                            input logic [7:0] b);
        return (mode == CSUM_XOR) ? (acc ^ b) : (acc + b);
    endfunction

    function automatic logic [7:0] csumFinal(input int unsigned mode, input logic [7:0] acc);
        return (mode == CSUM_NEG) ? (~acc + 8'd1) : acc;
    endfunction

endpackage

// File: rtl/uart_packet_tx_if.sv
// Producer-side packet handshake and status for uart_packet_tx.
interface uart_packet_tx_if #(
    parameter int unsigned BYTES = 4
);
    logic [BYTES*8-1:0] packetData;
    logic               packetValid;
    logic               packetReady;
    logic               packetSent;
    logic               busy;

    modport master (
        output packetData,
        output packetValid,
        input  packetReady,
        input  packetSent,
        input  busy
    );

    modport slave (
        input  packetData,
        input  packetValid,
        output packetReady,
        output packetSent,
        output busy
    );
endinterface

// File: rtl/uart_byte_tx.sv
// Single 8N1 character serialiser; done marks the last clock of the stop bit so the
// next character can be loaded on that same edge with no gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKDIVIDER = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       done
);
    localparam int unsigned DivW = (CLKDIVIDER > 1) ? $clog2(CLKDIVIDER) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLKDIVIDER - 1);
    localparam logic [3:0] BitLast = 4'(UART_FRAME_BITS - 1);

    logic [UART_FRAME_BITS-1:0] shiftQ, shiftD;
    logic [DivW-1:0]            divCntQ, divCntD;
    logic [3:0]                 bitCntQ, bitCntD;
    logic                       activeQ, activeD;
    logic                       bitEnd, load;

    assign bitEnd = activeQ && (divCntQ == DivLast);
    assign done   = bitEnd && (bitCntQ == BitLast);
    assign ready  = !activeQ;
    assign load   = start && (ready || done);
    // Idle level is forced from activeQ so an async reset drives the line high at once.
    assign tx     = activeQ ? shiftQ[0] : 1'b1;

    always_comb begin
        shiftD  = shiftQ;
        divCntD = divCntQ;
        bitCntD = bitCntQ;
        activeD = activeQ;
        if (load) begin
            shiftD  = {1'b1, data, 1'b0};
            divCntD = '0;
            bitCntD = '0;
            activeD = 1'b1;
        end else if (bitEnd) begin
            divCntD = '0;
            if (bitCntQ == BitLast) begin
                activeD = 1'b0;
            end else begin
                bitCntD = bitCntQ + 4'd1;
                shiftD  = {1'b1, shiftQ[UART_FRAME_BITS-1:1]};
            end
        end else if (activeQ) begin
            divCntD = divCntQ + DivW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftQ  <= '1;
            divCntQ <= '0;
            bitCntQ <= '0;
            activeQ <= 1'b0;
        end else begin
            shiftQ  <= shiftD;
            divCntQ <= divCntD;
            bitCntQ <= bitCntD;
            activeQ <= activeD;
        end
    end

endmodule

// File: rtl/uart_packet_tx.sv
// Framed packet transmitter: optional sync byte, data bytes MSB-first, then a checksum byte,
// all as back-to-back 8N1 characters.
module uart_packet_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKDIVIDER = 50,
    parameter int unsigned BYTES      = 4,
    parameter int unsigned SYNC_EN    = 1,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned CSUM_MODE  = 0,
    parameter logic [7:0]  CSUM_INIT  = 8'h00
) (
    input  logic   clk,
    input  logic   rst_n,
    uart_packet_tx_if.slave pkt,
    output logic   tx
);
    localparam int unsigned DataW = BYTES * 8;
    localparam int unsigned IdxW  = $clog2(BYTES + 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(BYTES - 1);

    txState_t          stateQ, stateD;
    logic [DataW-1:0]  pktQ, pktD;
    logic [IdxW-1:0]   idxQ, idxD;
    logic [7:0]        csumQ, csumD;
    logic              sentQ, sentD;
    logic              byteStart, byteReady, byteDone;
    logic [7:0]        byteData, pktTop, inTop;
    logic              accept;

    assign pktTop          = pktQ[DataW-1 -: 8];
    assign inTop           = pkt.packetData[DataW-1 -: 8];
    assign pkt.packetReady = (stateQ == StIdle) && byteReady;
    assign pkt.busy        = (stateQ != StIdle);
    assign pkt.packetSent  = sentQ;
    assign accept          = pkt.packetValid && pkt.packetReady;

    // Every character after the first is launched on the serialiser's done edge,
    // which keeps characters back-to-back.
    always_comb begin
        stateD    = stateQ;
        pktD      = pktQ;
        idxD      = idxQ;
        csumD     = csumQ;
        sentD     = 1'b0;
        byteStart = 1'b0;
        byteData  = pktTop;
        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    byteStart = 1'b1;
                    idxD      = '0;
                    if (SYNC_EN != 0) begin
                        byteData = SYNC_BYTE;
                        pktD     = pkt.packetData;
                        csumD    = CSUM_INIT;
                        stateD   = StSync;
                    end else begin
                        byteData = inTop;
                        pktD     = pkt.packetData << 8;
                        csumD    = csumStep(CSUM_MODE, CSUM_INIT, inTop);
                        stateD   = StData;
                    end
                end
            end
            StSync: begin
                if (byteDone) begin
                    byteStart = 1'b1;
                    pktD      = pktQ << 8;
                    csumD     = csumStep(CSUM_MODE, csumQ, pktTop);
                    stateD    = StData;
                end
            end
            StData: begin
                if (byteDone) begin
                    byteStart = 1'b1;
                    if (idxQ == IdxLast) begin
                        byteData = csumFinal(CSUM_MODE, csumQ);
                        stateD   = StCsum;
                    end else begin
                        pktD  = pktQ << 8;
                        csumD = csumStep(CSUM_MODE, csumQ, pktTop);
                        idxD  = idxQ + IdxW'(1);
                    end
                end
            end
            StCsum: begin
                if (byteDone) begin
                    stateD = StIdle;
                    sentD  = 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            pktQ   <= '0;
            idxQ   <= '0;
            csumQ  <= CSUM_INIT;
            sentQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            pktQ   <= pktD;
            idxQ   <= idxD;
            csumQ  <= csumD;
            sentQ  <= sentD;
        end
    end

    uart_byte_tx #(
        .CLKDIVIDER(CLKDIVIDER)
    ) uByteTx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(byteStart),
        .data (byteData),
        .tx   (tx),
        .ready(byteReady),
        .done (byteDone)
    );

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx across several parameter sets; decodes tx per bit window.
module tb_uart_packet_tx;

    logic       clk;
    logic       rst_n;
    logic [5:0] txv;
    logic [5:0] sentv, readyv, busyv;
    int         checks   = 0;
    int         failures = 0;

    uart_packet_tx_if #(.BYTES(4)) p0 ();
    uart_packet_tx_if #(.BYTES(4)) p1 ();
    uart_packet_tx_if #(.BYTES(4)) p2 ();
    uart_packet_tx_if #(.BYTES(1)) p3 ();
    uart_packet_tx_if #(.BYTES(4)) p4 ();
    uart_packet_tx_if #(.BYTES(4)) p5 ();

    uart_packet_tx #(.CLKDIVIDER(4), .CSUM_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .pkt(p0.slave), .tx(txv[0]));
    uart_packet_tx #(.CLKDIVIDER(4), .CSUM_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .pkt(p1.slave), .tx(txv[1]));
    uart_packet_tx #(.CLKDIVIDER(4), .CSUM_MODE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .pkt(p2.slave), .tx(txv[2]));
    uart_packet_tx #(.CLKDIVIDER(4), .BYTES(1), .SYNC_EN(0), .CSUM_MODE(0),
                     .CSUM_INIT(8'h0F)) u3 (
        .clk(clk), .rst_n(rst_n), .pkt(p3.slave), .tx(txv[3]));
    uart_packet_tx #(.CLKDIVIDER(2)) u4 (
        .clk(clk), .rst_n(rst_n), .pkt(p4.slave), .tx(txv[4]));
    uart_packet_tx #(.CLKDIVIDER(50)) u5 (
        .clk(clk), .rst_n(rst_n), .pkt(p5.slave), .tx(txv[5]));

    assign sentv  = {p5.packetSent, p4.packetSent, p3.packetSent,
                     p2.packetSent, p1.packetSent, p0.packetSent};
    assign readyv = {p5.packetReady, p4.packetReady, p3.packetReady,
                     p2.packetReady, p1.packetReady, p0.packetReady};
    assign busyv  = {p5.busy, p4.busy, p3.busy, p2.busy, p1.busy, p0.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at the falling edge inside the first start-bit clock; returns at the falling
    // edge of the first clock after the final stop bit.
    task automatic recvFrame(input int k, input int div, input int nChars,
                             output logic [63:0] got, output int shapeErr, output int ctrlErr);
        logic [7:0] b;
        got      = '0;
        shapeErr = 0;
        ctrlErr  = 0;
        for (int c = 0; c < nChars; c++) begin
            b = '0;
            for (int bi = 0; bi < 10; bi++) begin
                for (int t = 0; t < div; t++) begin
                    if (bi == 0) begin
                        if (txv[k] !== 1'b0) shapeErr++;
                    end else if (bi == 9) begin
                        if (txv[k] !== 1'b1) shapeErr++;
                    end else if (t == 0) begin
                        b[bi-1] = txv[k];
                    end else if (txv[k] !== b[bi-1]) begin
                        shapeErr++;
                    end
                    if (sentv[k] !== 1'b0 || readyv[k] !== 1'b0 || busyv[k] !== 1'b1)
                        ctrlErr++;
                    @(negedge clk);
                end
            end
            got = {got[55:0], b};
        end
    endtask

    task automatic frameCheck(input string tag, input int k, input int div, input int n,
                              input logic [63:0] exp, output logic [63:0] got);
        int se, ce;
        recvFrame(k, div, n, got, se, ce);
        chk({tag, "_bytes"}, got, exp);
        chk({tag, "_bits"}, 64'(se), 64'd0);
        chk({tag, "_ctrl"}, 64'(ce), 64'd0);
        chk({tag, "_end"}, {60'd0, sentv[k], readyv[k], busyv[k], txv[k]}, 64'hD);
    endtask

    logic [63:0] got;
    int          pulses;

    initial begin
        rst_n = 1'b0;
        p0.packetValid = 1'b0; p0.packetData = '0;
        p1.packetValid = 1'b0; p1.packetData = '0;
        p2.packetValid = 1'b0; p2.packetData = '0;
        p3.packetValid = 1'b0; p3.packetData = '0;
        p4.packetValid = 1'b0; p4.packetData = '0;
        p5.packetValid = 1'b0; p5.packetData = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 64'(txv), 64'h3F);
        chk("rst_ready", 64'(readyv), 64'h3F);
        chk("rst_busy_sent", 64'({busyv, sentv}), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst", 64'({txv, readyv, busyv, sentv}), 64'hFFF000);

        // Single frame, sync + XOR checksum; sent expected 241 clocks after accept.
        p0.packetData = 32'h11223344; p0.packetValid = 1'b1;
        @(negedge clk);
        p0.packetValid = 1'b0;
        frameCheck("xor", 0, 4, 6, 64'hA5_11_22_33_44_44, got);
        @(negedge clk);
        chk("xor_sent_once", 64'(sentv[0]), 64'd0);

        // Three words with packetValid held; source data changes mid-frame.
        p0.packetData = 32'h11223344; p0.packetValid = 1'b1;
        @(negedge clk);
        p0.packetData = 32'hDEADBEEF;
        frameCheck("b2b1", 0, 4, 6, 64'hA5_11_22_33_44_44, got);
        @(negedge clk);
        p0.packetData = 32'h00010203;
        frameCheck("b2b2", 0, 4, 6, 64'hA5_DE_AD_BE_EF_22, got);
        @(negedge clk);
        p0.packetValid = 1'b0;
        p0.packetData  = 32'hFFFFFFFF;
        frameCheck("b2b3", 0, 4, 6, 64'hA5_00_01_02_03_00, got);
        @(negedge clk);
        chk("b2b_idle", 64'({sentv[0], readyv[0], busyv[0], txv[0]}), 64'h5);

        // Reset in the start bit of the second data byte.
        p0.packetData = 32'h11223344; p0.packetValid = 1'b1;
        @(negedge clk);
        p0.packetValid = 1'b0;
        repeat (81) @(negedge clk);
        chk("midrst_pre", 64'({txv[0], busyv[0]}), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_async", 64'(txv[0]), 64'd1);
        chk("midrst_ctrl_async", 64'({readyv[0], busyv[0], sentv[0]}), 64'h4);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(sentv[0]);
        end
        rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            pulses += int'(sentv[0]);
        end
        chk("midrst_no_sent", 64'(pulses), 64'd0);
        chk("midrst_ready", 64'({readyv[0], txv[0]}), 64'h3);
        p0.packetData = 32'h55AA00FF; p0.packetValid = 1'b1;
        @(negedge clk);
        p0.packetValid = 1'b0;
        frameCheck("after_rst", 0, 4, 6, 64'hA5_55_AA_00_FF_00, got);

        // Sum mod 256.
        p1.packetData = 32'h11223344; p1.packetValid = 1'b1;
        @(negedge clk);
        p1.packetValid = 1'b0;
        frameCheck("sum", 1, 4, 6, 64'hA5_11_22_33_44_AA, got);

        // Two's complement of sum; data plus checksum must vanish mod 256.
        p2.packetData = 32'h11223344; p2.packetValid = 1'b1;
        @(negedge clk);
        p2.packetValid = 1'b0;
        frameCheck("neg", 2, 4, 6, 64'hA5_11_22_33_44_56, got);
        chk("neg_zero", 64'(8'(8'h11 + 8'h22 + 8'h33 + 8'h44 + got[7:0])), 64'd0);

        // No sync, one byte, non-zero init: 80-clock frame.
        p3.packetData = 8'hFF; p3.packetValid = 1'b1;
        @(negedge clk);
        p3.packetValid = 1'b0;
        frameCheck("nosync", 3, 4, 2, 64'hFF_F0, got);

        // Bit-time extremes.
        p4.packetData = 32'h11223344; p4.packetValid = 1'b1;
        @(negedge clk);
        p4.packetValid = 1'b0;
        frameCheck("div2", 4, 2, 6, 64'hA5_11_22_33_44_44, got);

        p5.packetData = 32'h0FF0817E; p5.packetValid = 1'b1;
        @(negedge clk);
        p5.packetValid = 1'b0;
        frameCheck("div50", 5, 50, 6, 64'hA5_0F_F0_81_7E_00, got);
        @(negedge clk);
        chk("div50_sent_once", 64'(sentv[5]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
